// File: rtl/alu_retire_stage_pkg.sv
// Shared types and helpers for the ALU retire stage.
// Holds the branch condition codes, flag bit positions, the beat
// carried through the skid buffer, and the condition evaluator.
package alu_pkg;

  // Beat geometry. These must agree with the top-level DATA_W / REG_AW.
  localparam int BEAT_DATA_W = 32;
  localparam int BEAT_REG_AW = 4;
  localparam int COND_BITS   = 4;

  // Bit positions inside the 4-bit flags word.
  localparam int FLAG_Z = 3;
  localparam int FLAG_B = 2;
  localparam int FLAG_S = 1;
  localparam int FLAG_V = 0;

  // Branch condition codes; 9..15 are "never".
  typedef enum logic [COND_BITS-1:0] {
    COND_AL  = 4'd0,
    COND_EQ  = 4'd1,
    COND_NE  = 4'd2,
    COND_LTU = 4'd3,
    COND_GEU = 4'd4,
    COND_LT  = 4'd5,
    COND_GE  = 4'd6,
    COND_LE  = 4'd7,
    COND_GT  = 4'd8
  } cond_e;

  // Writeback beat held by the skid buffer.
  typedef struct packed {
    logic [BEAT_DATA_W-1:0] res;
    logic [BEAT_REG_AW-1:0] rd;
    logic                   wen;
  } retire_beat_t;

  // Evaluates a condition code against a flags word.
  function automatic logic cond_taken(input logic [COND_BITS-1:0] cond,
                                      input logic [3:0]           f);
    logic lt;
    logic taken;
    lt    = f[FLAG_S] ^ f[FLAG_V];
    taken = 1'b0;
    case (cond)
      COND_AL:  taken = 1'b1;
      COND_EQ:  taken = f[FLAG_Z];
      COND_NE:  taken = !f[FLAG_Z];
      COND_LTU: taken = f[FLAG_B];
      COND_GEU: taken = !f[FLAG_B];
      COND_LT:  taken = lt;
      COND_GE:  taken = !lt;
      COND_LE:  taken = f[FLAG_Z] | lt;
      COND_GT:  taken = !f[FLAG_Z] & !lt;
      default:  taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/alu_retire_stage_skid_buf.sv
// Two-entry skid buffer carrying retire_beat_t.
// The main entry drives the outputs; the skid entry catches one beat
// when the downstream stalls. in_ready comes straight from a flop.
module retire_skid_buf
  import alu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  retire_beat_t in_beat,
  output logic         out_valid,
  input  logic         out_ready,
  output retire_beat_t out_beat
);

  logic         main_valid;
  logic         skid_valid;
  retire_beat_t main_q;
  retire_beat_t skid_q;
  logic         accept;
  logic         xfer;

  assign accept    = in_valid && in_ready;
  assign xfer      = main_valid && out_ready;
  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign out_beat  = main_q;

  // Occupancy and main-entry contents: refill from skid first, then from input.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
    end else if (xfer) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_q     <= in_beat;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (!main_valid) begin
      if (accept) begin
        main_q     <= in_beat;
        main_valid <= 1'b1;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
    end
  end

  // Skid payload: captured when a beat arrives while main is full and stalled.
  // NOTE: payload-only storage has no reset; skid_valid alone says whether it is meaningful.
  always_ff @(posedge clk) begin
    if (accept && main_valid && !out_ready) begin
      skid_q <= in_beat;
    end
  end

endmodule

// File: rtl/alu_retire_stage.sv
// ALU retire stage: buffers ALU results toward writeback, maintains the
// architectural flags and resolves conditional branches at accept time.
// Optional feature macro: ALU_RETIRE_PERF_EN adds retire/stall counters.
module alu_retire_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4,
  parameter int COND_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_res,
  input  logic [3:0]        in_flags,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_wen,
  input  logic              in_setflags,
  input  logic              in_isbranch,
  input  logic [COND_W-1:0] in_cond,
  input  logic [DATA_W-1:0] in_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_res,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_wen,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_target,
  output logic [3:0]        flags_q
`ifdef ALU_RETIRE_PERF_EN
  ,
  output logic [31:0]       perf_retired,
  output logic [31:0]       perf_stall
`endif
);

  retire_beat_t in_beat;
  retire_beat_t out_beat;
  logic         accept;
  logic [3:0]   eff_flags;
  logic         br_hit;

  assign in_beat = '{res: in_res, rd: in_rd, wen: in_wen};

  retire_skid_buf u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_beat   (in_beat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_beat  (out_beat)
  );

  assign out_res = out_beat.res;
  assign out_rd  = out_beat.rd;
  assign out_wen = out_beat.wen;

  assign accept = in_valid && in_ready;

  // A compare-and-branch beat resolves against the flags it carries itself.
  always_comb begin
    eff_flags = in_setflags ? in_flags : flags_q;
    br_hit    = accept && in_isbranch && cond_taken(in_cond, eff_flags);
  end

  // Architectural flags update at accept, independent of writeback timing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
    end else if (accept && in_setflags) begin
      flags_q <= in_flags;
    end
  end

  // One-cycle taken pulse with its target; downstream stalls do not delay it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_taken  <= 1'b0;
      branch_target <= '0;
    end else begin
      branch_taken <= br_hit;
      if (br_hit) begin
        branch_target <= in_target;
      end
    end
  end

`ifdef ALU_RETIRE_PERF_EN
  // Retired-beat and stall-cycle counters, wrapping naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_retired <= '0;
      perf_stall   <= '0;
    end else begin
      if (out_valid && out_ready) begin
        perf_retired <= perf_retired + 32'd1;
      end
      if (out_valid && !out_ready) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_retire_stage.sv
// Self-checking bench for alu_retire_stage: directed scenarios followed by
// randomized traffic, with a scoreboard queue and a negedge monitor.
module tb_alu_retire_stage;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_res, in_target;
  logic [3:0]  in_flags, in_rd, in_cond;
  logic        in_wen, in_setflags, in_isbranch;
  logic        out_valid, out_ready;
  logic [31:0] out_res, branch_target;
  logic [3:0]  out_rd, flags_q;
  logic        out_wen, branch_taken;
`ifdef ALU_RETIRE_PERF_EN
  logic [31:0] perf_retired, perf_stall;
  int unsigned m_retired = 0, m_stall = 0;
`endif

  always #5 clk = ~clk;

  alu_retire_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_res(in_res),
    .in_flags(in_flags), .in_rd(in_rd), .in_wen(in_wen),
    .in_setflags(in_setflags), .in_isbranch(in_isbranch),
    .in_cond(in_cond), .in_target(in_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_rd(out_rd), .out_wen(out_wen),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .flags_q(flags_q)
`ifdef ALU_RETIRE_PERF_EN
    , .perf_retired(perf_retired), .perf_stall(perf_stall)
`endif
  );

  typedef struct {
    bit          valid;
    logic [31:0] res;
    logic [3:0]  rd;
    bit          wen;
    bit          setf;
    logic [3:0]  flags;
    bit          isbr;
    int          cond;
    logic [31:0] target;
  } stim_t;

  int total = 0;
  int bad   = 0;

  // Reference state
  retire_beat_t sb[$];
  logic [3:0]   m_flags = 4'd0;
  logic [3:0]   exp_flags_now = 4'd0;
  bit           br_pend = 0, exp_br_now = 0;
  logic [31:0]  tgt_pend = '0, exp_tgt_now = '0;
  int           exp_cnt = 0;
  bit           mon_en = 0;
  bit           prev_stall = 0;
  retire_beat_t prev_out;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural branch rule from the condition-code table.
  function automatic bit ref_taken(input int c, input logic [3:0] f);
    bit z, b, lt;
    z  = f[3];
    b  = f[2];
    lt = (f[1] != f[0]);
    case (c)
      0: return 1'b1;
      1: return z;
      2: return !z;
      3: return b;
      4: return !b;
      5: return lt;
      6: return !lt;
      7: return z || lt;
      8: return !z && !lt;
      default: return 1'b0;
    endcase
  endfunction

  // Applies one cycle of stimulus just after a rising edge and records expectations.
  task automatic drive(input stim_t s, input logic oready, output bit acc);
    logic [3:0] f;
    @(posedge clk); #1;
    exp_br_now    = br_pend;
    exp_tgt_now   = tgt_pend;
    exp_flags_now = m_flags;
    in_valid    = s.valid;
    in_res      = s.res;
    in_rd       = s.rd;
    in_wen      = s.wen;
    in_setflags = s.setf;
    in_flags    = s.flags;
    in_isbranch = s.isbr;
    in_cond     = 4'(s.cond);
    in_target   = s.target;
    out_ready   = oready;
    acc = s.valid && (in_ready === 1'b1);
    br_pend = 0;
    if (acc) begin
      sb.push_back('{res: s.res, rd: s.rd, wen: s.wen});
      if (s.isbr) begin
        f = s.setf ? s.flags : m_flags;
        br_pend  = ref_taken(s.cond, f);
        tgt_pend = s.target;
      end
      if (s.setf) m_flags = s.flags;
    end
  endtask

  function automatic stim_t beat(input logic [31:0] res, input logic [3:0] rd);
    stim_t s;
    s = '{valid: 1, res: res, rd: rd, wen: 1, setf: 0, flags: 4'd0,
          isbr: 0, cond: 0, target: 32'd0};
    return s;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = beat(32'd0, 4'd0);
    s.valid = 0;
    return s;
  endfunction

  // Monitor: checks handshake/flags/branch every cycle and pops the scoreboard on transfer.
  always @(negedge clk) begin
    if (mon_en) begin
      retire_beat_t e;
      check("in_ready", {31'd0, in_ready}, {31'd0, exp_cnt < 2});
      check("out_valid", {31'd0, out_valid}, {31'd0, exp_cnt > 0});
      check("flags_q", {28'd0, flags_q}, {28'd0, exp_flags_now});
      check("branch_taken", {31'd0, branch_taken}, {31'd0, exp_br_now});
      if (exp_br_now) check("branch_target", branch_target, exp_tgt_now);
      if (prev_stall) begin
        check("stall_res", out_res, prev_out.res);
        check("stall_rd", {28'd0, out_rd}, {28'd0, prev_out.rd});
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_nonempty", 32'd0, 32'd1);
        end else begin
          e = sb.pop_front();
          check("out_res", out_res, e.res);
          check("out_rd", {28'd0, out_rd}, {28'd0, e.rd});
          check("out_wen", {31'd0, out_wen}, {31'd0, e.wen});
        end
      end
`ifdef ALU_RETIRE_PERF_EN
      if (out_valid && out_ready) m_retired++;
      if (out_valid && !out_ready) m_stall++;
`endif
      prev_stall = out_valid && !out_ready;
      prev_out   = '{res: out_res, rd: out_rd, wen: out_wen};
      exp_cnt += ((in_valid && in_ready) ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
    end
  end

  task automatic clear_model();
    sb.delete();
    m_flags = 4'd0; exp_flags_now = 4'd0;
    br_pend = 0; exp_br_now = 0; tgt_pend = '0; exp_tgt_now = '0;
    exp_cnt = 0; prev_stall = 0;
`ifdef ALU_RETIRE_PERF_EN
    m_retired = 0; m_stall = 0;
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_out_res"}, out_res, 32'd0);
    check({tag, "_out_rd"}, {28'd0, out_rd}, 32'd0);
    check({tag, "_out_wen"}, {31'd0, out_wen}, 32'd0);
    check({tag, "_branch_taken"}, {31'd0, branch_taken}, 32'd0);
    check({tag, "_branch_target"}, branch_target, 32'd0);
    check({tag, "_flags_q"}, {28'd0, flags_q}, 32'd0);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    bit    acc;
    stim_t s;
    bit    pend;
    int    n;

    rst = 1'b1;
    in_valid = 0; in_res = '0; in_flags = '0; in_rd = '0; in_wen = 0;
    in_setflags = 0; in_isbranch = 0; in_cond = '0; in_target = '0;
    out_ready = 1'b1;
    #12;
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    mon_en = 1;

    // Single beat with downstream ready: visible one cycle later.
    drive(beat(32'h0000_00AB, 4'd5), 1'b1, acc);
    check("single_acc", {31'd0, acc}, 32'd1);
    drive(idle(), 1'b1, acc);
    check("single_valid", {31'd0, out_valid}, 32'd1);
    check("single_res", out_res, 32'h0000_00AB);
    check("single_rd", {28'd0, out_rd}, 32'd5);
    check("single_in_ready", {31'd0, in_ready}, 32'd1);
    drive(idle(), 1'b1, acc);

    // Back-to-back beats into a stalled downstream.
    drive(beat(32'd1, 4'd1), 1'b0, acc);
    drive(beat(32'd2, 4'd2), 1'b0, acc);
    drive(beat(32'd3, 4'd3), 1'b0, acc);
    check("b3_refused", {31'd0, acc}, 32'd0);
    check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    check("stall_main", out_res, 32'd1);
    drive(beat(32'd3, 4'd3), 1'b0, acc);
    n = 0;
    do begin
      drive(beat(32'd3, 4'd3), 1'b1, acc);
      n++;
    end while (!acc && n < 8);
    check("b3_accepted", {31'd0, acc}, 32'd1);
    repeat (4) drive(idle(), 1'b1, acc);

    // Reset while both entries are full and a taken pulse is live.
    drive(beat(32'h11, 4'd1), 1'b0, acc);
    s = beat(32'h22, 4'd2);
    s.isbr = 1; s.cond = 0; s.target = 32'hCAFE_0000;
    drive(s, 1'b0, acc);
    @(posedge clk); #2;
    mon_en = 0;
    check("pre_rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("pre_rst_pulse", {31'd0, branch_taken}, 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("mid");
    in_valid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    mon_en = 1;

    // Compare-and-branch: LT taken on its own flags, then GE not taken.
    s = beat(32'h33, 4'd3);
    s.setf = 1; s.flags = 4'b0010; s.isbr = 1; s.cond = 5; s.target = 32'h0000_1000;
    drive(s, 1'b1, acc);
    s.cond = 6; s.target = 32'h0000_2000;
    drive(s, 1'b1, acc);
    check("lt_taken", {31'd0, branch_taken}, 32'd1);
    check("lt_target", branch_target, 32'h0000_1000);
    drive(idle(), 1'b1, acc);
    check("ge_not_taken", {31'd0, branch_taken}, 32'd0);
    check("flags_0010", {28'd0, flags_q}, 32'b0010);

    // setflags Z, then EQ branch on stored flags.
    s = beat(32'h44, 4'd4);
    s.setf = 1; s.flags = 4'b1000;
    drive(s, 1'b1, acc);
    s = beat(32'h55, 4'd5);
    s.isbr = 1; s.cond = 1; s.target = 32'hDEAD_BEE0;
    drive(s, 1'b1, acc);
    drive(idle(), 1'b1, acc);
    check("eq_taken", {31'd0, branch_taken}, 32'd1);
    check("eq_target", branch_target, 32'hDEAD_BEE0);
    check("eq_flags", {28'd0, flags_q}, 32'b1000);
    drive(idle(), 1'b1, acc);
    check("eq_one_cycle", {31'd0, branch_taken}, 32'd0);

    // Randomized traffic; an offered beat is held until accepted.
    pend = 0;
    for (int i = 0; i < 400; i++) begin
      if (!pend) begin
        s.res    = $urandom;
        s.rd     = 4'($urandom_range(0, 15));
        s.wen    = $urandom_range(0, 1);
        s.setf   = ($urandom_range(0, 2) == 0);
        s.flags  = 4'($urandom_range(0, 15));
        s.isbr   = ($urandom_range(0, 2) == 0);
        s.cond   = $urandom_range(0, 15);
        s.target = $urandom;
        pend     = ($urandom_range(0, 3) != 0);
      end
      s.valid = pend;
      drive(s, 1'($urandom_range(0, 9) < 6), acc);
      if (acc) pend = 0;
    end

    // Drain with a bounded wait.
    n = 0;
    do begin
      drive(idle(), 1'b1, acc);
      n++;
    end while ((sb.size() != 0 || out_valid) && n < 20);
    drive(idle(), 1'b1, acc);
    check("drain_empty", sb.size(), 32'd0);

`ifdef ALU_RETIRE_PERF_EN
    @(negedge clk);
    check("perf_retired", perf_retired, m_retired);
    check("perf_stall", perf_stall, m_stall);
`endif

    mon_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
